// File: rtl/laser500_pkg.sv
// Shared types and default constants for the Laser 500 SDRAM arbitration logic.
package laser500_pkg;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_DIO,
    PORT_VID,
    PORT_CPU
  } port_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_ACCESS
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W   = 23;
  localparam int unsigned DEF_SLOT_LEN = 4;
  localparam int unsigned DEF_RD_LAT   = 3;
  localparam int unsigned SLOT_CNT_W   = 4;

  // Bit positions of each requester inside the 3-bit request vectors.
  localparam int unsigned P_DIO = 0;
  localparam int unsigned P_VID = 1;
  localparam int unsigned P_CPU = 2;

  function automatic logic [2:0] port_onehot(port_e p);
    case (p)
      PORT_DIO: return 3'b001;
      PORT_VID: return 3'b010;
      PORT_CPU: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational priority picker: dio > vid > cpu, with cpu promoted over vid when starved.
module sdram_arb_pick
  import laser500_pkg::*;
(
  input  logic [2:0] pend,
  input  logic       starve,
  output port_e      pick
);

  always_comb begin
    pick = PORT_NONE;
    if (pend[P_DIO])                 pick = PORT_DIO;
    else if (starve && pend[P_CPU])  pick = PORT_CPU;
    else if (pend[P_VID])            pick = PORT_VID;
    else if (pend[P_CPU])            pick = PORT_CPU;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Time-slot arbiter sharing one SDRAM controller port among data_io, video and the Z80.
// Define SDRAM_ARB_STARVE_GUARD_EN to force a cpu grant after two video grants while cpu waits.
module sdram_arbiter
  import laser500_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned SLOT_LEN = DEF_SLOT_LEN,
  parameter int unsigned RD_LAT   = DEF_RD_LAT
) (
  input  logic              F14M,
  input  logic              RESET,
  input  logic              dio_req,
  input  logic              dio_we,
  input  logic [ADDR_W-1:0] dio_addr,
  input  logic [7:0]        dio_din,
  output logic              dio_ack,
  output logic [7:0]        dio_dout,
  input  logic              vid_req,
  input  logic              vid_we,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [7:0]        vid_din,
  output logic              vid_ack,
  output logic [7:0]        vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  output logic              sd_oe,
  input  logic [7:0]        sd_dout
);

  arb_state_e            state, next_state;
  logic [SLOT_CNT_W-1:0] cnt;
  port_e                 winner, pick;
  logic [2:0]            pend, req_vec, busy_vec, eff_vec;
  logic                  slot_end, do_grant, starve;

  assign req_vec  = {cpu_req, vid_req, dio_req};
  assign slot_end = (state == ARB_ACCESS) && (cnt == SLOT_CNT_W'(SLOT_LEN - 1));
  // The owner's strobe in its own ack cycle is a fresh request, not a duplicate.
  assign busy_vec = (state == ARB_ACCESS && !slot_end) ? port_onehot(winner) : 3'b000;
  assign eff_vec  = pend | (req_vec & ~busy_vec);

  sdram_arb_pick u_pick (
    .pend   (eff_vec),
    .starve (starve),
    .pick   (pick)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) state <= ARB_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    next_state = state;
    do_grant   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (|eff_vec) begin
          do_grant   = 1'b1;
          next_state = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (slot_end) begin
          if (|eff_vec) do_grant   = 1'b1;
          else          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET) begin
      pend     <= '0;
      cnt      <= '0;
      winner   <= PORT_NONE;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_we    <= 1'b0;
      sd_oe    <= 1'b0;
      dio_dout <= '0;
      vid_dout <= '0;
      cpu_dout <= '0;
    end else begin
      pend <= eff_vec & ~(do_grant ? port_onehot(pick) : 3'b000);
      if (do_grant) begin
        cnt    <= '0;
        winner <= pick;
        case (pick)
          PORT_DIO: begin sd_addr <= dio_addr; sd_din <= dio_din; sd_we <= dio_we; sd_oe <= ~dio_we; end
          PORT_VID: begin sd_addr <= vid_addr; sd_din <= vid_din; sd_we <= vid_we; sd_oe <= ~vid_we; end
          PORT_CPU: begin sd_addr <= cpu_addr; sd_din <= cpu_din; sd_we <= cpu_we; sd_oe <= ~cpu_we; end
          default: ;
        endcase
      end else if (slot_end) begin
        cnt    <= '0;
        winner <= PORT_NONE;
        sd_we  <= 1'b0;
        sd_oe  <= 1'b0;
      end else if (state == ARB_ACCESS) begin
        cnt <= cnt + 1'b1;
      end

      if (state == ARB_ACCESS && sd_oe && cnt == SLOT_CNT_W'(RD_LAT)) begin
        case (winner)
          PORT_DIO: dio_dout <= sd_dout;
          PORT_VID: vid_dout <= sd_dout;
          PORT_CPU: cpu_dout <= sd_dout;
          default: ;
        endcase
      end
    end
  end

  assign dio_ack = slot_end && (winner == PORT_DIO);
  assign vid_ack = slot_end && (winner == PORT_VID);
  assign cpu_ack = slot_end && (winner == PORT_CPU);

`ifdef SDRAM_ARB_STARVE_GUARD_EN
  logic [1:0] vid_run;

  assign starve = (vid_run == 2'd2);

  always_ff @(posedge F14M or posedge RESET) begin
    if (RESET)                           vid_run <= '0;
    else if (!eff_vec[P_CPU])            vid_run <= '0;
    else if (do_grant) begin
      if (pick == PORT_CPU)              vid_run <= '0;
      else if (pick == PORT_VID && !starve) vid_run <= vid_run + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: scoreboard of expected acks plus a small SDRAM model.
module tb_sdram_arbiter;
  import laser500_pkg::*;

  localparam int ADDR_W   = 23;
  localparam int SLOT_LEN = 4;
  localparam int RD_LAT   = 3;

  logic F14M = 1'b0;
  logic RESET = 1'b1;
  logic [2:0] req_v = '0;
  logic dio_we = 0, vid_we = 0, cpu_we = 0;
  logic [ADDR_W-1:0] dio_addr = '0, vid_addr = '0, cpu_addr = '0;
  logic [7:0] dio_din = '0, vid_din = '0, cpu_din = '0;
  logic dio_ack, vid_ack, cpu_ack;
  logic [7:0] dio_dout, vid_dout, cpu_dout;
  logic [ADDR_W-1:0] sd_addr;
  logic [7:0] sd_din, sd_dout;
  logic sd_we, sd_oe;

  sdram_arbiter #(.ADDR_W(ADDR_W), .SLOT_LEN(SLOT_LEN), .RD_LAT(RD_LAT)) dut (
    .F14M(F14M), .RESET(RESET),
    .dio_req(req_v[0]), .dio_we(dio_we), .dio_addr(dio_addr), .dio_din(dio_din),
    .dio_ack(dio_ack), .dio_dout(dio_dout),
    .vid_req(req_v[1]), .vid_we(vid_we), .vid_addr(vid_addr), .vid_din(vid_din),
    .vid_ack(vid_ack), .vid_dout(vid_dout),
    .cpu_req(req_v[2]), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
  );

  always #5 F14M = ~F14M;

  int cyc = 0;
  always @(posedge F14M) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SDRAM model: tracks slot position from sd_oe/sd_we, drives data only at RD_LAT.
  logic [7:0] mem [0:255];
  int idx = -1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h41;
    mem[8'h02] = 8'h5A;
  end

  always @(posedge F14M) begin
    #1;
    if (!(sd_oe || sd_we))                    idx = -1;
    else if (idx == -1 || idx == SLOT_LEN-1)  idx = 0;
    else                                      idx = idx + 1;
    if (idx == 0 && sd_we) mem[sd_addr[7:0]] = sd_din;
  end

  assign sd_dout = (sd_oe && idx == RD_LAT) ? mem[sd_addr[7:0]] : 8'hEE;

  typedef struct {
    port_e      port;
    logic       rd;
    logic [7:0] data;
    int         ack_cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [7:0] dout_of(input port_e p);
    case (p)
      PORT_DIO: return dio_dout;
      PORT_VID: return vid_dout;
      PORT_CPU: return cpu_dout;
      default:  return 8'hXX;
    endcase
  endfunction

  function automatic exp_t mk(input port_e p, input logic rd, input logic [7:0] d, input int c);
    exp_t e;
    e.port = p; e.rd = rd; e.data = d; e.ack_cyc = c;
    return e;
  endfunction

  logic       dchk = 1'b0;
  port_e      dchk_port = PORT_NONE;
  logic [7:0] dchk_data = '0;

  always @(negedge F14M) begin
    port_e ap;
    exp_t  e;
    if (dchk) begin
      check("rd_data", {24'd0, dout_of(dchk_port)}, {24'd0, dchk_data});
      dchk = 1'b0;
    end
    if (dio_ack || vid_ack || cpu_ack) begin
      check("one_ack", $countones({dio_ack, vid_ack, cpu_ack}), 1);
      ap = dio_ack ? PORT_DIO : (vid_ack ? PORT_VID : PORT_CPU);
      if (sb.size() == 0) begin
        check("spurious_ack", {30'd0, ap}, {30'd0, PORT_NONE});
      end else begin
        e = sb.pop_front();
        check("ack_port", {30'd0, ap}, {30'd0, e.port});
        check("ack_cyc", cyc, e.ack_cyc);
        if (e.rd) begin
          dchk      = 1'b1;
          dchk_port = e.port;
          dchk_data = e.data;
        end
      end
    end
  end

  task automatic setp(input port_e p, input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    case (p)
      PORT_DIO: begin dio_we = we; dio_addr = a; dio_din = d; end
      PORT_VID: begin vid_we = we; vid_addr = a; vid_din = d; end
      PORT_CPU: begin cpu_we = we; cpu_addr = a; cpu_din = d; end
      default: ;
    endcase
  endtask

  // Called at the negedge of the strobe cycle; returns at the negedge of the next cycle.
  task automatic pulse(input logic [2:0] m);
    req_v = m;
    @(negedge F14M);
    req_v = '0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge F14M);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n;

  initial begin
    repeat (3) @(negedge F14M);
    check("rst_sd_oe", sd_oe, 0);
    check("rst_sd_we", sd_we, 0);
    check("rst_sd_addr", sd_addr, 0);
    check("rst_sd_din", sd_din, 0);
    check("rst_acks", {dio_ack, vid_ack, cpu_ack}, 0);
    check("rst_douts", {dio_dout, vid_dout, cpu_dout}, 0);
    RESET = 1'b0;
    repeat (2) @(negedge F14M);

    // Single cpu read.
    setp(PORT_CPU, 1'b0, 23'h1F800, 8'h00);
    n = cyc;
    sb.push_back(mk(PORT_CPU, 1'b1, 8'h41, n + 4));
    pulse(3'b100);
    check("t1_addr", sd_addr, 23'h1F800);
    for (int k = 1; k <= 5; k++) begin
      check("t1_sd_oe", sd_oe, (k <= 4) ? 1 : 0);
      check("t1_sd_we", sd_we, 0);
      @(negedge F14M);
    end
    repeat (3) @(negedge F14M);

    // Three simultaneous write strobes.
    setp(PORT_DIO, 1'b1, 23'h00010, 8'h11);
    setp(PORT_VID, 1'b1, 23'h00020, 8'h22);
    setp(PORT_CPU, 1'b1, 23'h00030, 8'h33);
    n = cyc;
    sb.push_back(mk(PORT_DIO, 1'b0, 8'h00, n + 4));
    sb.push_back(mk(PORT_VID, 1'b0, 8'h00, n + 8));
    sb.push_back(mk(PORT_CPU, 1'b0, 8'h00, n + 12));
    pulse(3'b111);
    for (int k = 1; k <= 13; k++) begin
      check("t2_sd_we", sd_we, (k <= 12) ? 1 : 0);
      if (k == 1) check("t2_addr_dio", sd_addr, 23'h00010);
      if (k == 5) check("t2_addr_vid", sd_addr, 23'h00020);
      if (k == 9) check("t2_addr_cpu", sd_addr, 23'h00030);
      @(negedge F14M);
    end
    check("t2_mem_dio", mem[8'h10], 8'h11);
    check("t2_mem_vid", mem[8'h20], 8'h22);
    check("t2_mem_cpu", mem[8'h30], 8'h33);
    check("t2_cpu_dout_kept", cpu_dout, 8'h41);

    // cpu write then read-back.
    setp(PORT_CPU, 1'b1, 23'h1F801, 8'h42);
    n = cyc;
    sb.push_back(mk(PORT_CPU, 1'b0, 8'h00, n + 4));
    pulse(3'b100);
    check("t3_wr_we", sd_we, 1);
    check("t3_wr_oe", sd_oe, 0);
    wait_to(n + 7);
    setp(PORT_CPU, 1'b0, 23'h1F801, 8'h00);
    n = cyc;
    sb.push_back(mk(PORT_CPU, 1'b1, 8'h42, n + 4));
    pulse(3'b100);
    check("t3_rd_oe", sd_oe, 1);
    check("t3_rd_we", sd_we, 0);
    wait_to(n + 7);
    check("t3_cpu_dout", cpu_dout, 8'h42);
    check("t3_vid_dout", vid_dout, 8'h00);
    check("t3_dio_dout", dio_dout, 8'h00);

    // Continuous video load with cpu waiting.
    setp(PORT_VID, 1'b0, 23'h1F802, 8'h00);
    setp(PORT_CPU, 1'b0, 23'h1F800, 8'h00);
    n = cyc;
`ifdef SDRAM_ARB_STARVE_GUARD_EN
    sb.push_back(mk(PORT_VID, 1'b1, 8'h5A, n + 4));
    sb.push_back(mk(PORT_VID, 1'b1, 8'h5A, n + 8));
    sb.push_back(mk(PORT_CPU, 1'b1, 8'h41, n + 12));
    sb.push_back(mk(PORT_VID, 1'b1, 8'h5A, n + 16));
    sb.push_back(mk(PORT_VID, 1'b1, 8'h5A, n + 20));
`else
    for (int k = 1; k <= 5; k++) sb.push_back(mk(PORT_VID, 1'b1, 8'h5A, n + 4*k));
    sb.push_back(mk(PORT_CPU, 1'b1, 8'h41, n + 24));
`endif
    pulse(3'b110);
    for (int k = 1; k <= 4; k++) begin
      wait_to(n + 4*k);
      pulse(3'b010);
    end
    wait_to(n + 30);
    check("t4_sb_drained", sb.size(), 0);

    // Duplicate cpu strobe while in flight.
    setp(PORT_CPU, 1'b0, 23'h1F801, 8'h00);
    n = cyc;
    sb.push_back(mk(PORT_CPU, 1'b1, 8'h42, n + 4));
    pulse(3'b100);
    wait_to(n + 2);
    pulse(3'b100);
    wait_to(n + 14);
    check("t6_sb_drained", sb.size(), 0);

    // Reset at slot cycle 2 of a cpu read, with vid pending.
    setp(PORT_CPU, 1'b0, 23'h1F800, 8'h00);
    n = cyc;
    pulse(3'b100);
    pulse(3'b010);
    wait_to(n + 3);
    RESET = 1'b1;
    #1;
    check("t5_sd_oe", sd_oe, 0);
    check("t5_sd_addr", sd_addr, 0);
    check("t5_cpu_ack", cpu_ack, 0);
    check("t5_douts", {dio_dout, vid_dout, cpu_dout}, 0);
    @(negedge F14M);
    RESET = 1'b0;
    wait_to(cyc + 10);
    check("t5_idle_oe", sd_oe, 0);
    n = cyc;
    sb.push_back(mk(PORT_CPU, 1'b1, 8'h41, n + 4));
    pulse(3'b100);
    check("t5_rd_oe", sd_oe, 1);
    wait_to(n + 10);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
